// File: rtl/clk_freq_meter.sv
// clk_freq_meter: measures a divided clock over a fixed gate window of clk cycles.
// A start pulse opens a window of GATE_CYCLES cycles. In that window the meter counts
// rising edges (saturating) and high cycles of the synchronized input. The results
// are published together with a one-cycle done pulse.
// Ports:
//   clk, rst       system clock and synchronous active-high reset
//   sig_in         asynchronous signal under measurement
//   start          request a measurement; only accepted while idle
//   busy           window open
//   done           one-cycle pulse marking an update of the result outputs
//   edge_count     rising edges seen in the last window (saturating)
//   high_cycles    window cycles with synchronized sig_in high
//   overflow       edge_count saturated during the last window
module clk_freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned GATE_W     = $clog2(GATE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  edge_count,
    output logic [GATE_W-1:0] high_cycles,
    output logic              overflow
);

    typedef enum logic {IDLE, MEAS} state_t;

    localparam logic [CNT_W-1:0]  EDGE_MAX = '1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    s_d_q, s_d_d;
    logic [GATE_W-1:0]       gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]        edge_acc_q, edge_acc_d;
    logic [GATE_W-1:0]       high_acc_q, high_acc_d;
    logic                    sat_q, sat_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        edge_count_q, edge_count_d;
    logic [GATE_W-1:0]       high_cycles_q, high_cycles_d;
    logic                    overflow_q, overflow_d;

    // Synchronized level, its rising edge, and the accumulator values including this cycle
    logic              s_c;
    logic              rise_c;
    logic [CNT_W-1:0]  edge_nxt_c;
    logic [GATE_W-1:0] high_nxt_c;
    logic              sat_nxt_c;

    always_comb begin
        s_c        = sync_q[SYNC_STAGES-1];
        rise_c     = s_c & ~s_d_q;
        edge_nxt_c = edge_acc_q;
        sat_nxt_c  = sat_q;
        // An edge that would wrap the accumulator is dropped and flagged instead
        if (rise_c) begin
            if (edge_acc_q == EDGE_MAX) begin
                sat_nxt_c = 1'b1;
            end else begin
                edge_nxt_c = edge_acc_q + CNT_W'(1);
            end
        end
        high_nxt_c = high_acc_q + GATE_W'(s_c);
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_d_d         = s_c;
        gate_cnt_d    = gate_cnt_q;
        edge_acc_d    = edge_acc_q;
        high_acc_d    = high_acc_q;
        sat_d         = sat_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        edge_count_d  = edge_count_q;
        high_cycles_d = high_cycles_q;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = MEAS;
                    busy_d     = 1'b1;
                    gate_cnt_d = '0;
                    edge_acc_d = '0;
                    high_acc_d = '0;
                    sat_d      = 1'b0;
                end
            end
            MEAS: begin
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                edge_acc_d = edge_nxt_c;
                high_acc_d = high_nxt_c;
                sat_d      = sat_nxt_c;
                // Last window cycle: publish results including this cycle's sample
                if (gate_cnt_q == GATE_LAST) begin
                    state_d       = IDLE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    edge_count_d  = edge_nxt_c;
                    high_cycles_d = high_nxt_c;
                    overflow_d    = sat_nxt_c;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            s_d_q         <= 1'b0;
            gate_cnt_q    <= '0;
            edge_acc_q    <= '0;
            high_acc_q    <= '0;
            sat_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            edge_count_q  <= '0;
            high_cycles_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            s_d_q         <= s_d_d;
            gate_cnt_q    <= gate_cnt_d;
            edge_acc_q    <= edge_acc_d;
            high_acc_q    <= high_acc_d;
            sat_q         <= sat_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            edge_count_q  <= edge_count_d;
            high_cycles_q <= high_cycles_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign edge_count  = edge_count_q;
    assign high_cycles = high_cycles_q;
    assign overflow    = overflow_q;

endmodule
